// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte sources,
// with busy tracking, a start-of-busy timeout and an idle gap between bytes.
module uart_tx_sched #(
    parameter int N_REQ   = 4,
    parameter int GAP     = 16,
    parameter int BUSY_TO = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               transmit,
    output logic [7:0]         data_tx,
    output logic               active,
    output logic               err
);

    localparam int PW = $clog2(N_REQ);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // With GAP=0 a finished byte returns straight to IDLE
    localparam state_t AFTER_BYTE = (GAP == 0) ? S_IDLE : S_GAP;
    localparam logic AFTER_ACTIVE = (GAP != 0);

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     sel;
    logic [GW-1:0]     gcnt;
    logic [TW-1:0]     tcnt;
    logic [N_REQ-1:0]  sel_hot;
    logic [7:0]        sel_byte;

    // Scan downward so the closest set bit after ptr is the last written
    always_comb begin
        int idx;
        idx = 0;
        sel = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) sel = PW'(idx);
        end
    end

    assign sel_hot  = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
    assign sel_byte = data[8*sel +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            transmit <= 1'b0;
            data_tx  <= 8'h00;
            active   <= 1'b0;
            err      <= 1'b0;
            ptr      <= PW'(N_REQ - 1);
            gcnt     <= '0;
            tcnt     <= '0;
        end else begin
            grant    <= '0;
            transmit <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        data_tx  <= sel_byte;
                        grant    <= sel_hot;
                        transmit <= 1'b1;
                        ptr      <= sel;
                        tcnt     <= '0;
                        active   <= 1'b1;
                        state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tcnt == TO_LAST) begin
                        err    <= 1'b1;
                        gcnt   <= GAP_LOAD;
                        active <= AFTER_ACTIVE;
                        state  <= AFTER_BYTE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        gcnt   <= GAP_LOAD;
                        active <= AFTER_ACTIVE;
                        state  <= AFTER_BYTE;
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) begin
                        active <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
